// File: rtl/usb_pkg.sv
// Shared USB definitions: PID constants in wire (LSB-first) order and the
// device transaction state encoding.
package usb_pkg;

  localparam logic [7:0] PID_OUT   = 8'b1000_0111;
  localparam logic [7:0] PID_IN    = 8'b1001_0110;
  localparam logic [7:0] PID_DATA0 = 8'b1100_0011;
  localparam logic [7:0] PID_DATA1 = 8'b1101_0010;
  localparam logic [7:0] PID_ACK   = 8'b0100_1011;
  localparam logic [7:0] PID_NAK   = 8'b0101_1010;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX_DATA = 3'd1,
    ST_TX_HAND = 3'd2,
    ST_TX_DATA = 3'd3,
    ST_RX_HAND = 3'd4
  } state_t;

endpackage

// File: rtl/usb_retry_cnt.sv
// Saturating 4-bit retry counter with clear, increment and a flag that marks
// the final permitted attempt (count == MAX_RETRY-1). Used by both the host
// and device transaction sequencers.
module usb_retry_cnt #(
  parameter int MAX_RETRY = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_last
);

  logic [3:0] r_cnt;

  // Count failed attempts; clear wins over increment and the count never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (i_clr) begin
      r_cnt <= 4'd0;
    end else if (i_inc && (r_cnt != 4'hF)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_last = (r_cnt == 4'(MAX_RETRY - 1));

endmodule

// File: rtl/usb_dev_txn_fsm.sv
// Device-side USB transaction sequencer. Runs OUT (receive data, answer
// ACK/NAK) and IN (send data, await host handshake) transactions with a
// bounded retry count and emits one txn_done pulse per completed transaction.
// Optional build macro USB_DEV_DATA_TOGGLE_EN: alternate DATA0/DATA1 on each
// successful IN; without it data_pid is fixed at DATA0.
module usb_dev_txn_fsm
  import usb_pkg::*;
#(
  parameter int MAX_RETRY = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tok_valid,
  input  logic [7:0] tok_pid,
  output logic       r_data_start,
  input  logic       r_data_finish,
  input  logic       r_data_success,
  input  logic       r_data_fail,
  output logic       start_send_data,
  output logic [7:0] data_pid,
  input  logic       done_send_data,
  output logic       start_send_hand,
  output logic [7:0] hand_pid,
  input  logic       done_send_hand,
  output logic       r_hand,
  input  logic       receive,
  input  logic       ack,
  input  logic       nak,
  input  logic       r_hand_fail,
  output logic       txn_done,
  output logic       txn_success
);

  state_t     r_state;
  logic       r_rx_start;
  logic       r_tx_start;
  logic       r_hs_start;
  logic       r_hr_start;
  logic       r_done;
  logic       r_success;
  logic [7:0] r_hand_pid;

  logic w_last;
  logic w_clr;
  logic w_inc;
  logic w_in_fail;
  logic w_in_ack;

  assign w_in_fail = r_hand_fail | nak;
  assign w_in_ack  = receive & ack;

  // A new transaction restarts the attempt count; a non-final failure bumps it.
  assign w_clr = (r_state == ST_IDLE) && tok_valid &&
                 ((tok_pid == PID_OUT) || (tok_pid == PID_IN));
  assign w_inc = !w_last &&
                 (((r_state == ST_RX_DATA) && r_data_fail) ||
                  ((r_state == ST_RX_HAND) && w_in_fail));

  usb_retry_cnt #(.MAX_RETRY(MAX_RETRY)) u_retry (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_last (w_last)
  );

  // Transaction sequencer: every strobe is a registered single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rx_start <= 1'b0;
      r_tx_start <= 1'b0;
      r_hs_start <= 1'b0;
      r_hr_start <= 1'b0;
      r_done     <= 1'b0;
      r_success  <= 1'b0;
      r_hand_pid <= PID_NAK;
    end else begin
      r_rx_start <= 1'b0;
      r_tx_start <= 1'b0;
      r_hs_start <= 1'b0;
      r_hr_start <= 1'b0;
      r_done     <= 1'b0;
      r_success  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tok_valid) begin
            if (tok_pid == PID_OUT) begin
              r_state    <= ST_RX_DATA;
              r_rx_start <= 1'b1;
            end else if (tok_pid == PID_IN) begin
              r_state    <= ST_TX_DATA;
              r_tx_start <= 1'b1;
            end
          end
        end
        ST_RX_DATA: begin
          // A bad packet on the last attempt ends silently: no handshake.
          if (r_data_fail) begin
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_hand_pid <= PID_NAK;
              r_hs_start <= 1'b1;
              r_state    <= ST_TX_HAND;
            end
          end else if (r_data_finish && r_data_success) begin
            r_hand_pid <= PID_ACK;
            r_hs_start <= 1'b1;
            r_state    <= ST_TX_HAND;
          end
        end
        ST_TX_HAND: begin
          // The handshake just sent decides between completion and a re-receive.
          if (done_send_hand) begin
            if (r_hand_pid == PID_ACK) begin
              r_done    <= 1'b1;
              r_success <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_rx_start <= 1'b1;
              r_state    <= ST_RX_DATA;
            end
          end
        end
        ST_TX_DATA: begin
          if (done_send_data) begin
            r_hr_start <= 1'b1;
            r_state    <= ST_RX_HAND;
          end
        end
        ST_RX_HAND: begin
          // Timeout/bad packet or NAK outranks a simultaneous ACK.
          if (w_in_fail) begin
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_tx_start <= 1'b1;
              r_state    <= ST_TX_DATA;
            end
          end else if (w_in_ack) begin
            r_done    <= 1'b1;
            r_success <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef USB_DEV_DATA_TOGGLE_EN
  logic r_toggle;

  // Advance DATA0/DATA1 only once the host has acknowledged IN data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_toggle <= 1'b0;
    end else if ((r_state == ST_RX_HAND) && !w_in_fail && w_in_ack) begin
      r_toggle <= ~r_toggle;
    end
  end

  assign data_pid = r_toggle ? PID_DATA1 : PID_DATA0;
`else
  assign data_pid = PID_DATA0;
`endif

  assign r_data_start    = r_rx_start;
  assign start_send_data = r_tx_start;
  assign start_send_hand = r_hs_start;
  assign r_hand          = r_hr_start;
  assign hand_pid        = r_hand_pid;
  assign txn_done        = r_done;
  assign txn_success     = r_success;

endmodule
